// File: rtl/npu_pio_pkg.sv
// Shared PIO command definitions: header field positions, response codes,
// response word layout and decoder state encoding.
package npu_pio_pkg;

    localparam int unsigned MAX_ARGS   = 4;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned OPCODE_W   = 8;
    localparam int unsigned TAG_W      = 16;
    localparam int unsigned STATUS_W   = 7;
    localparam int unsigned NARGS_W    = 8;

    // Header word field positions
    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 24;
    localparam int unsigned NARGS_MSB  = 23;
    localparam int unsigned NARGS_LSB  = 16;
    localparam int unsigned TAG_MSB    = 15;
    localparam int unsigned TAG_LSB    = 0;

    // Response codes
    localparam logic [7:0] RESP_DONE      = 8'hA5;
    localparam logic [7:0] RESP_BAD_NARGS = 8'hE0;
    localparam logic [7:0] RESP_TIMEOUT   = 8'hE1;

    typedef logic [OPCODE_W-1:0] opcode_t;

    typedef struct packed {
        logic [7:0]          code;
        logic                overrun;
        logic [STATUS_W-1:0] status;
        logic [TAG_W-1:0]    tag;
    } resp_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARGS      = 2'd1,
        ST_ISSUE     = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    // Assemble a response word from its fields
    function automatic logic [WORD_W-1:0] make_resp(input logic [7:0]          code,
                                                    input logic                ovr,
                                                    input logic [STATUS_W-1:0] status,
                                                    input logic [TAG_W-1:0]    tag);
        resp_t r;
        r.code    = code;
        r.overrun = ovr;
        r.status  = status;
        r.tag     = tag;
        return WORD_W'(r);
    endfunction

endpackage

// File: rtl/pio_cmd_decoder.sv
// PIO command decoder: assembles header + argument words from the host into a
// command for the core, then returns one response word per command.
// Optional argument timeout enabled with macro PIO_CMD_TIMEOUT_EN.
module pio_cmd_decoder
    import npu_pio_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [WORD_W-1:0]                  h2f_pio32,
    input  logic                               h2f_write,
    output logic [WORD_W-1:0]                  f2h_pio32,
    output logic                               f2h_write,
    output logic                               cmd_valid,
    input  logic                               cmd_ready,
    output logic [OPCODE_W-1:0]                cmd_opcode,
    output logic [TAG_W-1:0]                   cmd_tag,
    output logic [MAX_ARGS-1:0][WORD_W-1:0]    cmd_args,
    input  logic                               done_valid,
    input  logic [STATUS_W-1:0]                done_status
);

    localparam int unsigned IDX_W = $clog2(MAX_ARGS);
    localparam int unsigned CNT_W = $clog2(MAX_ARGS + 1);

    state_t                          state_q, state_d;
    logic [CNT_W-1:0]                nargs_q, nargs_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic                            overrun_q, overrun_d;
    logic [WORD_W-1:0]               f2h_pio32_d;
    logic                            f2h_write_d;
    logic                            cmd_valid_d;
    logic [OPCODE_W-1:0]             cmd_opcode_d;
    logic [TAG_W-1:0]                cmd_tag_d;
    logic [MAX_ARGS-1:0][WORD_W-1:0] cmd_args_d;

    logic [NARGS_W-1:0]              hdr_nargs;
    logic                            last_arg;

`ifdef PIO_CMD_TIMEOUT_EN
    localparam int unsigned TCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TCNT_W-1:0]               tcnt_q, tcnt_d;
`else
    // TIMEOUT_CYCLES is accepted but has no effect without the timeout feature
    if (TIMEOUT_CYCLES == 0) begin : g_timeout_ignored
    end
`endif

    assign hdr_nargs = h2f_pio32[NARGS_MSB:NARGS_LSB];
    assign last_arg  = (CNT_W'(idx_q) + CNT_W'(1)) == nargs_q;

    // Next-state and next-output decode
    always_comb begin
        state_d      = state_q;
        nargs_d      = nargs_q;
        idx_d        = idx_q;
        overrun_d    = overrun_q;
        f2h_pio32_d  = f2h_pio32;
        f2h_write_d  = 1'b0;
        cmd_valid_d  = cmd_valid;
        cmd_opcode_d = cmd_opcode;
        cmd_tag_d    = cmd_tag;
        cmd_args_d   = cmd_args;
`ifdef PIO_CMD_TIMEOUT_EN
        tcnt_d       = tcnt_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (h2f_write) begin
                    if (hdr_nargs > NARGS_W'(MAX_ARGS)) begin
                        f2h_write_d = 1'b1;
                        f2h_pio32_d = make_resp(RESP_BAD_NARGS, overrun_q, '0,
                                                h2f_pio32[TAG_MSB:TAG_LSB]);
                        overrun_d   = 1'b0;
                    end else begin
                        cmd_opcode_d = h2f_pio32[OPCODE_MSB:OPCODE_LSB];
                        cmd_tag_d    = h2f_pio32[TAG_MSB:TAG_LSB];
                        cmd_args_d   = '0;
                        nargs_d      = CNT_W'(hdr_nargs);
                        idx_d        = '0;
`ifdef PIO_CMD_TIMEOUT_EN
                        tcnt_d       = '0;
`endif
                        if (hdr_nargs == '0) begin
                            cmd_valid_d = 1'b1;
                            state_d     = ST_ISSUE;
                        end else begin
                            state_d     = ST_ARGS;
                        end
                    end
                end
            end
            ST_ARGS: begin
                if (h2f_write) begin
                    cmd_args_d[idx_q] = h2f_pio32;
                    idx_d             = idx_q + IDX_W'(1);
`ifdef PIO_CMD_TIMEOUT_EN
                    tcnt_d            = '0;
`endif
                    if (last_arg) begin
                        cmd_valid_d = 1'b1;
                        state_d     = ST_ISSUE;
                    end
                end
`ifdef PIO_CMD_TIMEOUT_EN
                else if (tcnt_q == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
                    f2h_write_d = 1'b1;
                    f2h_pio32_d = make_resp(RESP_TIMEOUT, overrun_q, '0, cmd_tag);
                    overrun_d   = 1'b0;
                    tcnt_d      = '0;
                    state_d     = ST_IDLE;
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
`endif
            end
            ST_ISSUE: begin
                if (h2f_write) overrun_d = 1'b1;
                if (cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    state_d     = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (h2f_write) overrun_d = 1'b1;
                if (done_valid) begin
                    f2h_write_d = 1'b1;
                    f2h_pio32_d = make_resp(RESP_DONE, overrun_q | h2f_write,
                                            done_status, cmd_tag);
                    overrun_d   = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            nargs_q    <= '0;
            idx_q      <= '0;
            overrun_q  <= 1'b0;
            f2h_pio32  <= '0;
            f2h_write  <= 1'b0;
            cmd_valid  <= 1'b0;
            cmd_opcode <= '0;
            cmd_tag    <= '0;
            cmd_args   <= '0;
`ifdef PIO_CMD_TIMEOUT_EN
            tcnt_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            nargs_q    <= nargs_d;
            idx_q      <= idx_d;
            overrun_q  <= overrun_d;
            f2h_pio32  <= f2h_pio32_d;
            f2h_write  <= f2h_write_d;
            cmd_valid  <= cmd_valid_d;
            cmd_opcode <= cmd_opcode_d;
            cmd_tag    <= cmd_tag_d;
            cmd_args   <= cmd_args_d;
`ifdef PIO_CMD_TIMEOUT_EN
            tcnt_q     <= tcnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_pio_cmd_decoder.sv
// Self-checking bench for pio_cmd_decoder. Expected responses are queued as
// commands are driven and compared by a monitor whenever f2h_write fires.
module tb_pio_cmd_decoder;

    logic                    clk;
    logic                    rst_n;
    logic [31:0]             h2f_pio32;
    logic                    h2f_write;
    logic [31:0]             f2h_pio32;
    logic                    f2h_write;
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [7:0]              cmd_opcode;
    logic [15:0]             cmd_tag;
    logic [3:0][31:0]        cmd_args;
    logic                    done_valid;
    logic [6:0]              done_status;

    int n_vec;
    int n_err;
    logic [31:0] exp_q[$];

    pio_cmd_decoder #(.TIMEOUT_CYCLES(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .h2f_pio32   (h2f_pio32),
        .h2f_write   (h2f_write),
        .f2h_pio32   (f2h_pio32),
        .f2h_write   (f2h_write),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_opcode  (cmd_opcode),
        .cmd_tag     (cmd_tag),
        .cmd_args    (cmd_args),
        .done_valid  (done_valid),
        .done_status (done_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Response monitor: every f2h_write must match the oldest queued response
    always @(negedge clk) begin
        if (rst_n && f2h_write) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL resp_unexpected: got %08h, no response expected", f2h_pio32);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (f2h_pio32 !== e) begin
                    n_err++;
                    $display("FAIL resp_word: got %08h, expected %08h", f2h_pio32, e);
                end
            end
        end
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // All tasks start and end 1 time unit after a rising edge
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w);
        h2f_pio32 = w;
        h2f_write = 1'b1;
        tick(1);
        h2f_write = 1'b0;
    endtask

    task automatic accept();
        cmd_ready = 1'b1;
        tick(1);
        cmd_ready = 1'b0;
    endtask

    task automatic done(input logic [6:0] st);
        done_valid  = 1'b1;
        done_status = st;
        tick(1);
        done_valid  = 1'b0;
        done_status = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        n_vec++;
        if ({f2h_pio32, f2h_write, cmd_valid, cmd_opcode, cmd_tag, cmd_args} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got valid=%0b write=%0b pio=%08h, expected all 0",
                     cmd_valid, f2h_write, f2h_pio32);
        end
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_single();
        exp_q.push_back(32'hA5050ABC);
        send(32'h01000ABC);
        n_vec++;
        if (cmd_valid !== 1'b1 || cmd_opcode !== 8'h01 || cmd_tag !== 16'h0ABC || cmd_args !== '0) begin
            n_err++;
            $display("FAIL single_issue: got valid=%0b op=%02h tag=%04h, expected 1/01/0abc",
                     cmd_valid, cmd_opcode, cmd_tag);
        end
        // done_valid in ISSUE must be ignored; command stays held
        done(7'h33);
        tick(2);
        n_vec++;
        if (cmd_valid !== 1'b1 || cmd_tag !== 16'h0ABC) begin
            n_err++;
            $display("FAIL single_hold: got valid=%0b tag=%04h, expected 1/0abc", cmd_valid, cmd_tag);
        end
        accept();
        n_vec++;
        if (cmd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_accept: got valid=%0b, expected 0", cmd_valid);
        end
        done(7'h05);
        tick(2);
        // done_valid in IDLE must be ignored (monitor flags any response)
        done(7'h01);
        tick(2);
    endtask

    task automatic test_args();
        exp_q.push_back(32'hA57F0011);
        send(32'h02030011);
        send(32'h00000011);
        send(32'h00000022);
        n_vec++;
        if (cmd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL args_early: got valid=%0b, expected 0", cmd_valid);
        end
        send(32'h00000033);
        n_vec++;
        if (cmd_valid !== 1'b1 || cmd_opcode !== 8'h02 ||
            cmd_args !== {32'h0, 32'h33, 32'h22, 32'h11}) begin
            n_err++;
            $display("FAIL args_three: got valid=%0b op=%02h args=%032h, expected 1/02/%032h",
                     cmd_valid, cmd_opcode, cmd_args, {32'h0, 32'h33, 32'h22, 32'h11});
        end
        accept();
        done(7'h7F);
        tick(2);
        // Maximum argument count
        exp_q.push_back(32'hA5011234);
        send(32'h07041234);
        for (int i = 0; i < 4; i++) send(32'hC0DE0000 + 32'(i));
        n_vec++;
        if (cmd_valid !== 1'b1 ||
            cmd_args !== {32'hC0DE0003, 32'hC0DE0002, 32'hC0DE0001, 32'hC0DE0000}) begin
            n_err++;
            $display("FAIL args_four: got valid=%0b args=%032h", cmd_valid, cmd_args);
        end
        accept();
        done(7'h01);
        tick(2);
    endtask

    task automatic test_bad_count();
        exp_q.push_back(32'hE0000007);
        send(32'h03050007);
        n_vec++;
        if (f2h_write !== 1'b1 || f2h_pio32 !== 32'hE0000007 || cmd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bad_count: got write=%0b pio=%08h valid=%0b, expected 1/e0000007/0",
                     f2h_write, f2h_pio32, cmd_valid);
        end
        tick(1);
        n_vec++;
        if (f2h_write !== 1'b0) begin
            n_err++;
            $display("FAIL bad_count_pulse: got write=%0b, expected 0", f2h_write);
        end
        // Still in IDLE: a N=0 header issues immediately
        exp_q.push_back(32'hA5020055);
        send(32'h09000055);
        n_vec++;
        if (cmd_valid !== 1'b1 || cmd_opcode !== 8'h09) begin
            n_err++;
            $display("FAIL bad_count_idle: got valid=%0b op=%02h, expected 1/09", cmd_valid, cmd_opcode);
        end
        accept();
        done(7'h02);
        tick(2);
    endtask

    task automatic test_overrun();
        exp_q.push_back(32'hA5800100);
        send(32'h0A000100);
        accept();
        send(32'hFFFFFFFF);
        tick(2);
        done(7'h00);
        tick(2);
        exp_q.push_back(32'hA5000200);
        send(32'h0B000200);
        accept();
        done(7'h00);
        tick(2);
        // Overrun during ISSUE is reported on the next response too
        exp_q.push_back(32'hA5830300);
        send(32'h0C000300);
        send(32'h12345678);
        accept();
        done(7'h03);
        tick(2);
    endtask

    task automatic test_timeout();
`ifdef PIO_CMD_TIMEOUT_EN
        exp_q.push_back(32'hE1000042);
`endif
        send(32'h04020042);
        send(32'hAAAA0001);
        tick(20);
        n_vec++;
        if (cmd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_no_issue: got valid=%0b, expected 0", cmd_valid);
        end
`ifdef PIO_CMD_TIMEOUT_EN
        // Back in IDLE: new command decodes normally
        exp_q.push_back(32'hA5040043);
        send(32'h04000043);
        n_vec++;
        if (cmd_valid !== 1'b1 || cmd_tag !== 16'h0043) begin
            n_err++;
            $display("FAIL timeout_recover: got valid=%0b tag=%04h, expected 1/0043", cmd_valid, cmd_tag);
        end
`else
        // Still waiting for the second argument
        exp_q.push_back(32'hA5040042);
        send(32'hAAAA0002);
        n_vec++;
        if (cmd_valid !== 1'b1 || cmd_args !== {32'h0, 32'h0, 32'hAAAA0002, 32'hAAAA0001}) begin
            n_err++;
            $display("FAIL timeout_wait: got valid=%0b args=%032h, expected 1 and two args",
                     cmd_valid, cmd_args);
        end
`endif
        accept();
        done(7'h04);
        tick(2);
    endtask

    task automatic test_reset_mid();
        // Overrun pending in WAIT_DONE, then reset: flag and command discarded
        send(32'h0D000300);
        accept();
        send(32'h00000001);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        // Reset in ARGS
        send(32'h05030099);
        send(32'hBEEF0001);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({f2h_pio32, f2h_write, cmd_valid, cmd_opcode, cmd_tag, cmd_args} !== '0) begin
            n_err++;
            $display("FAIL reset_mid: got pio=%08h op=%02h tag=%04h args=%032h, expected all 0",
                     f2h_pio32, cmd_opcode, cmd_tag, cmd_args);
        end
        tick(3);
        rst_n = 1'b1;
        tick(1);
        exp_q.push_back(32'hA5110123);
        send(32'h06010123);
        send(32'hDEADBEEF);
        n_vec++;
        if (cmd_valid !== 1'b1 || cmd_opcode !== 8'h06 || cmd_args !== {96'h0, 32'hDEADBEEF}) begin
            n_err++;
            $display("FAIL reset_recover: got valid=%0b op=%02h args=%032h, expected 1/06/deadbeef",
                     cmd_valid, cmd_opcode, cmd_args);
        end
        accept();
        done(7'h11);
        tick(2);
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        rst_n       = 1'b0;
        h2f_pio32   = '0;
        h2f_write   = 1'b0;
        cmd_ready   = 1'b0;
        done_valid  = 1'b0;
        done_status = '0;
        test_reset();
        test_single();
        test_args();
        test_bad_count();
        test_overrun();
        test_timeout();
        test_reset_mid();
        tick(5);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL resp_missing: %0d responses outstanding, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
